// File: rtl/fetch_pc_unit.sv
// Instruction-fetch PC/nPC unit for a MIPS-style delayed-branch pipeline.
// Optional advancing-fetch counter is compiled in with FETCH_COUNT_EN.
module fetch_pc_unit #(
  parameter int unsigned ADDR_W   = 9,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LE,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  output logic [ADDR_W-1:0] Instr_Addr,
  output logic [31:0]       PC_out,
  output logic [31:0]       nPC_out,
  output logic [31:0]       PC_plus8,
  output logic              Fetch_Valid,
`ifdef FETCH_COUNT_EN
  output logic [31:0]       Fetch_Count,
`endif
  output logic              Redirect_Pending
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   npc_q, npc_d;
  logic [XLEN-1:0]   pend_q, pend_d;
  logic              pend_vld_q, pend_vld_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic [XLEN-1:0]   ta_c;
  logic [XLEN-1:0]   npc_inc_c;

  assign ta_c      = Branch_Target & ~XLEN'(3);
  assign npc_inc_c = npc_q + XLEN'(4);

  // Next-state: BOOT idles one cycle, RUN advances or enters STALL, STALL parks a redirect.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    npc_d         = npc_q;
    pend_d        = pend_q;
    pend_vld_d    = pend_vld_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (LE) begin
          pc_d  = npc_q;
          npc_d = Branch_Taken ? ta_c : npc_inc_c;
        end else begin
          state_d = ST_STALL;
          if (Branch_Taken) begin
            pend_d     = ta_c;
            pend_vld_d = 1'b1;
          end
        end
      end
      ST_STALL: begin
        if (LE) begin
          state_d    = ST_RUN;
          pc_d       = npc_q;
          pend_vld_d = 1'b0;
          if (Branch_Taken)    npc_d = ta_c;
          else if (pend_vld_q) npc_d = pend_q;
          else                 npc_d = npc_inc_c;
        end else if (Branch_Taken) begin
          pend_d     = ta_c;
          pend_vld_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    fetch_valid_d = (state_d != ST_BOOT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + XLEN'(4);
      pend_q        <= '0;
      pend_vld_q    <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      pend_q        <= pend_d;
      pend_vld_q    <= pend_vld_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [XLEN-1:0] cnt_q, cnt_d;

  // Counts each edge on which the PC actually advances.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q != ST_BOOT) && LE) cnt_d = cnt_q + XLEN'(1);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign Fetch_Count = cnt_q;
`endif

  assign Instr_Addr       = pc_q[ADDR_W-1:0];
  assign PC_out           = pc_q;
  assign nPC_out          = npc_q;
  assign PC_plus8         = pc_q + XLEN'(8);
  assign Fetch_Valid      = fetch_valid_q;
  assign Redirect_Pending = pend_vld_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed self-checking bench for fetch_pc_unit: boot, branches, stalls, alignment, wrap, async reset.
module tb_fetch_pc_unit;

  logic        Clk;
  logic        Reset;
  logic        LE;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic [8:0]  Instr_Addr;
  logic [31:0] PC_out;
  logic [31:0] nPC_out;
  logic [31:0] PC_plus8;
  logic        Fetch_Valid;
  logic        Redirect_Pending;
`ifdef FETCH_COUNT_EN
  logic [31:0] Fetch_Count;
`endif

  int total = 0;
  int bad   = 0;

  fetch_pc_unit #(.ADDR_W(9), .RESET_PC(32'h0000_0000)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .LE               (LE),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .Instr_Addr       (Instr_Addr),
    .PC_out           (PC_out),
    .nPC_out          (nPC_out),
    .PC_plus8         (PC_plus8),
    .Fetch_Valid      (Fetch_Valid),
`ifdef FETCH_COUNT_EN
    .Fetch_Count      (Fetch_Count),
`endif
    .Redirect_Pending (Redirect_Pending)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle away from it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic le, input logic bt, input logic [31:0] ta);
    LE            = le;
    Branch_Taken  = bt;
    Branch_Target = ta;
  endtask

  initial begin
    Reset = 1'b0;
    drive(1'b1, 1'b0, 32'h0);
    step();
    step();
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_npc", nPC_out, 32'h4);
    chk("rst_pc8", PC_plus8, 32'h8);
    chk("rst_fv", 32'(Fetch_Valid), 32'h0);
    chk("rst_rp", 32'(Redirect_Pending), 32'h0);
`ifdef FETCH_COUNT_EN
    chk("rst_cnt", Fetch_Count, 32'h0);
`endif

    // Boot sequence: PC 0,0,4,8,12
    Reset = 1'b1;
    chk("c0_fv", 32'(Fetch_Valid), 32'h0);
    chk("c0_pc", PC_out, 32'h0);
    step();
    chk("c1_fv", 32'(Fetch_Valid), 32'h1);
    chk("c1_pc", PC_out, 32'h0);
    step();
    chk("c2_pc", PC_out, 32'h4);
    step();
    chk("c3_pc", PC_out, 32'h8);
    step();
    chk("c4_pc", PC_out, 32'hC);
    chk("c4_ia", 32'(Instr_Addr), 32'hC);
    step();
    chk("c5_pc", PC_out, 32'h10);
`ifdef FETCH_COUNT_EN
    chk("c5_cnt", Fetch_Count, 32'h4);
`endif

    // Taken branch at PC=0x10 to 0x100 with delay slot
    drive(1'b1, 1'b1, 32'h100);
    step();
    chk("br_slot_pc", PC_out, 32'h14);
    chk("br_npc", nPC_out, 32'h100);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("br_tgt_pc", PC_out, 32'h100);
    chk("br_tgt_pc8", PC_plus8, 32'h108);
    step();
    chk("br_next_pc", PC_out, 32'h104);

    // Reach PC=0x20
    drive(1'b1, 1'b1, 32'h20);
    step();
    chk("to20_slot", PC_out, 32'h108);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("to20_pc", PC_out, 32'h20);

    // Three stall cycles, branch pulse in the first
    drive(1'b0, 1'b1, 32'h200);
    step();
    chk("st1_pc", PC_out, 32'h20);
    chk("st1_rp", 32'(Redirect_Pending), 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    step();
    step();
    chk("st3_pc", PC_out, 32'h20);
    chk("st3_npc", nPC_out, 32'h24);
    chk("st3_rp", 32'(Redirect_Pending), 32'h1);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("rel_pc", PC_out, 32'h24);
    chk("rel_npc", nPC_out, 32'h200);
    chk("rel_rp", 32'(Redirect_Pending), 32'h0);
    step();
    chk("rel_tgt_pc", PC_out, 32'h200);

    // Live branch on release beats pending target
    drive(1'b0, 1'b1, 32'h300);
    step();
    chk("pri_st_pc", PC_out, 32'h200);
    chk("pri_st_rp", 32'(Redirect_Pending), 32'h1);
    drive(1'b1, 1'b1, 32'h400);
    step();
    chk("pri_rel_pc", PC_out, 32'h204);
    chk("pri_rel_npc", nPC_out, 32'h400);
    chk("pri_rel_rp", 32'(Redirect_Pending), 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("pri_tgt_pc", PC_out, 32'h400);
    step();
    chk("pri_next_pc", PC_out, 32'h404);

    // Last pending target wins across a multi-cycle stall
    drive(1'b0, 1'b1, 32'h500);
    step();
    drive(1'b0, 1'b1, 32'h600);
    step();
    chk("lw_st_pc", PC_out, 32'h404);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("lw_rel_pc", PC_out, 32'h408);
    chk("lw_rel_npc", nPC_out, 32'h600);
    step();
    chk("lw_tgt_pc", PC_out, 32'h600);

    // Misaligned target is forced to word alignment
    drive(1'b1, 1'b1, 32'h0000_0107);
    step();
    chk("al_npc", nPC_out, 32'h104);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("al_pc", PC_out, 32'h104);

    // Wrap at top of address space
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    step();
    chk("wr_npc", nPC_out, 32'hFFFF_FFFC);
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("wr_top_pc", PC_out, 32'hFFFF_FFFC);
    chk("wr_top_ia", 32'(Instr_Addr), 32'h1FC);
    chk("wr_top_pc8", PC_plus8, 32'h4);
    chk("wr_top_npc", nPC_out, 32'h0);
    step();
    chk("wr_pc", PC_out, 32'h0);

    // Async reset while a redirect is pending
    drive(1'b0, 1'b1, 32'h700);
    step();
    chk("ar_pre_rp", 32'(Redirect_Pending), 32'h1);
    drive(1'b0, 1'b0, 32'h0);
    #2;
    Reset = 1'b0;
    #1;
    chk("ar_pc", PC_out, 32'h0);
    chk("ar_npc", nPC_out, 32'h4);
    chk("ar_fv", 32'(Fetch_Valid), 32'h0);
    chk("ar_rp", 32'(Redirect_Pending), 32'h0);
`ifdef FETCH_COUNT_EN
    chk("ar_cnt", Fetch_Count, 32'h0);
`endif
    step();
    Reset = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    step();
    chk("ar_boot_fv", 32'(Fetch_Valid), 32'h1);
    chk("ar_boot_pc", PC_out, 32'h0);
    step();
    chk("ar_run_pc", PC_out, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch stage that feeds the IF/ID pipeline register. It holds the PC/nPC pair for the MIPS delayed-branch scheme and drives the instruction-memory address. It also supplies the PC and PC+8 values that travel down the pipeline. It honours the pipeline stall (LE) and holds a branch redirect that arrives while the stage is stalled until the stall is released.

Parameters:
ADDR_W, 9, width of instruction-memory byte address output
RESET_PC, 32'h0000_0000, PC value loaded on reset (nPC resets to RESET_PC+4)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-low reset (0 = reset asserted)
LE  input  1  load enable from hazard unit; 0 = stall, hold PC/nPC
Branch_Taken  input  1  branch/jump resolved taken in ID (one-cycle pulse)
Branch_Target  input  32  target address TA for taken branch/jump
Instr_Addr  output  ADDR_W  instruction-memory byte address = PC[ADDR_W-1:0]
PC_out  output  32  current fetch PC (to IF/ID PC input)
nPC_out  output  32  next PC register
PC_plus8  output  32  PC+8 for link instructions
Fetch_Valid  output  1  1 = Instr_Addr holds a real fetch; 0 = boot bubble
Redirect_Pending  output  1  a taken branch was captured during a stall and is not yet applied

Behaviour:
- Reset low (async): PC=RESET_PC, nPC=RESET_PC+4, pending register=0, Redirect_Pending=0, state=BOOT, Fetch_Valid=0. PC_plus8=RESET_PC+8 (combinational). Fetch count=0 when the optional feature is compiled in.
- States: BOOT, RUN, STALL. Fetch_Valid = (state != BOOT).
- BOOT: on the first posedge after Reset releases, go to RUN. PC/nPC hold, so the first real fetch is RESET_PC. Inputs are ignored in BOOT.
- RUN, LE=1:
  - Branch_Taken=1: PC<=nPC, nPC<=TA.
  - Branch_Taken=0: PC<=nPC, nPC<=nPC+4.
- RUN, LE=0: PC/nPC hold and the state goes to STALL. If Branch_Taken=1 in that cycle, TA is latched into the pending register and Redirect_Pending is set.
- STALL, LE=0: PC/nPC hold. A new Branch_Taken overwrites the pending target; the last one wins.
- STALL, LE=1: return to RUN. PC<=nPC.
  - nPC<=live TA if Branch_Taken=1 (live input has priority).
  - Otherwise nPC<=pending TA if Redirect_Pending=1.
  - Otherwise nPC<=nPC+4.
  - Redirect_Pending clears in all three cases.
- Delay slot: the instruction at the old nPC is always fetched after a taken branch. No squash is performed here.
- Alignment: TA[1:0] is forced to 2'b00 before use.
- Arithmetic: 32-bit modulo, so 32'hFFFF_FFFC+4 = 32'h0000_0000. Instr_Addr is truncation of PC, no range check.
- Latency: a redirect is visible on PC_out 2 edges after Branch_Taken when LE=1 (1 edge to nPC, 1 edge to PC).
- Reset asserted mid-stall or mid-redirect: all state is discarded immediately and the block returns to BOOT.

Optional Feature:
FETCH_COUNT_EN:
- Defined: adds output Fetch_Count[31:0]. It increments on every posedge where state is RUN or STALL and LE=1, i.e. each advancing fetch. It wraps at 2^32 and resets to 0.
- Undefined: no port, no counter logic; all other behaviour is identical.

Test Plan:
- Reset release, LE=1, no branches, 5 cycles:
  - Fetch_Valid=0 in cycle 0, then 1.
  - PC_out sequence 0, 0, 4, 8, 12.
  - Instr_Addr tracks PC[8:0].
- PC=0x10, Branch_Taken=1, TA=0x100, LE=1:
  - Next PC_out=0x14 (delay slot), then 0x100, then 0x104.
  - PC_plus8=0x108 when PC=0x100.
- LE=0 for 3 cycles at PC=0x20 with Branch_Taken pulse TA=0x200 in the 1st stall cycle:
  - PC holds 0x20 and Redirect_Pending=1.
  - On LE=1: PC=0x24, then 0x200; Redirect_Pending clears.
- Stall with pending TA=0x300, then a release cycle with live Branch_Taken TA=0x400 -> nPC=0x400; 0x300 is never fetched.
- TA=0x0000_0107 -> applied target 0x104. Also: force nPC=0xFFFF_FFFC, advance -> PC wraps to 0x0.
- Reset pulsed low while Redirect_Pending=1 -> outputs return to PC=0, nPC=4, Fetch_Valid=0, Redirect_Pending=0 without waiting for a clock edge. With FETCH_COUNT_EN defined, Fetch_Count=0.
